// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses UART command frames into single 32-bit bus reads/writes and returns response bytes.
module uart_bus_bridge #(
   parameter int unsigned FrameTimeout = 100000,
   parameter int unsigned BusTimeout   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rxByte,
   input  logic        rxValid,
   output logic [7:0]  txByte,
   output logic        txValid,
   input  logic        txReady,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic [3:0]  strobe,
   output logic        wen,
   output logic        ren,
   input  logic [31:0] rdata,
   input  logic        request_stall,
   input  logic        error,
   output logic        busy,
   output logic [7:0]  dropCount
);
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_REQ, BUS_DATA, RESP_HDR, RESP_DATA} state_t;
   localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;
   state_t state;
   logic wr, err;
   logic [1:0] cnt;
   logic [31:0] icnt, scnt, rbuf;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wr <= 1'b0;
         err <= 1'b0;
         cnt <= 2'd0;
         icnt <= 32'd0;
         scnt <= 32'd0;
         rbuf <= 32'd0;
         txByte <= 8'd0;
         txValid <= 1'b0;
         addr <= 32'd0;
         wdata <= 32'd0;
         strobe <= 4'd0;
         wen <= 1'b0;
         ren <= 1'b0;
         busy <= 1'b0;
         dropCount <= 8'd0;
      end else begin
         if (rxValid && !(state inside {IDLE, ADDR, WDATA}) && dropCount != 8'hff)
            dropCount <= dropCount + 8'd1;
         case (state)
            IDLE: if (rxValid) begin
               busy <= 1'b1;
               cnt <= 2'd0;
               icnt <= 32'd0;
               if (rxByte == 8'h52 || rxByte == 8'h57) begin
                  wr <= rxByte == 8'h57;
                  err <= 1'b0;
                  state <= ADDR;
               end else begin
                  err <= 1'b1;
                  txByte <= NAK;
                  txValid <= 1'b1;
                  state <= RESP_HDR;
               end
            end
            ADDR, WDATA: if (rxValid) begin
               icnt <= 32'd0;
               cnt <= cnt + 2'd1;
               if (state == ADDR) addr <= {addr[23:0], rxByte};
               else wdata <= {wdata[23:0], rxByte};
               if (cnt == 2'd3) begin
                  if (state == ADDR && wr) state <= WDATA;
                  else begin
                     state <= BUS_REQ;
                     wen <= wr;
                     ren <= !wr;
                     strobe <= 4'hf;
                     scnt <= 32'd0;
                  end
               end
            end else if (icnt == FrameTimeout - 1) begin
               state <= IDLE;
               busy <= 1'b0;
            end else icnt <= icnt + 32'd1;
            BUS_REQ: if (!request_stall) begin
               err <= error;
               wen <= 1'b0;
               ren <= 1'b0;
               strobe <= 4'd0;
               state <= BUS_DATA;
            end else if (scnt == BusTimeout - 1) begin
               err <= 1'b1;
               wen <= 1'b0;
               ren <= 1'b0;
               strobe <= 4'd0;
               txByte <= NAK;
               txValid <= 1'b1;
               state <= RESP_HDR;
            end else scnt <= scnt + 32'd1;
            BUS_DATA: begin
               rbuf <= rdata;
               err <= err || error;
               txByte <= (err || error) ? NAK : ACK;
               txValid <= 1'b1;
               state <= RESP_HDR;
            end
            RESP_HDR: if (txReady) begin
               cnt <= 2'd0;
               if (!wr && !err) begin
                  txByte <= rbuf[31:24];
                  rbuf <= {rbuf[23:0], 8'h00};
                  state <= RESP_DATA;
               end else begin
                  txValid <= 1'b0;
                  busy <= 1'b0;
                  state <= IDLE;
               end
            end
            RESP_DATA: if (txReady) begin
               cnt <= cnt + 2'd1;
               txByte <= rbuf[31:24];
               rbuf <= {rbuf[23:0], 8'h00};
               if (cnt == 2'd3) begin
                  txValid <= 1'b0;
                  busy <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed frames against a queue-based model of bus requests and response bytes.
module tb_uart_bus_bridge;
   logic clk = 1'b0, reset = 1'b1;
   logic [7:0] rxByte = 8'd0;
   logic rxValid = 1'b0, txReady = 1'b1;
   logic [7:0] txByte, dropCount;
   logic txValid, wen, ren, busy;
   logic [31:0] addr, wdata, rdata = 32'd0;
   logic [3:0] strobe;
   logic request_stall = 1'b0, error = 1'b0;

   uart_bus_bridge #(.FrameTimeout(16), .BusTimeout(8)) dut (
      .clk(clk), .reset(reset), .rxByte(rxByte), .rxValid(rxValid), .txByte(txByte),
      .txValid(txValid), .txReady(txReady), .addr(addr), .wdata(wdata), .strobe(strobe),
      .wen(wen), .ren(ren), .rdata(rdata), .request_stall(request_stall), .error(error),
      .busy(busy), .dropCount(dropCount)
   );

   always #5 clk = ~clk;

   typedef struct {bit w; logic [31:0] a; logic [31:0] d; int len;} bus_op_t;
   bus_op_t exp_bus[$];
   logic [7:0] exp_tx[$];
   logic [7:0] tx_log[$];
   int errors = 0, checks = 0;
   int stall_n = 0, last_len = 0, req_len = 0, mon_len = 0;
   bit hang = 0, berr = 0, acc = 0, prev_req = 0;
   logic [31:0] rd_value = 32'd0, seen_addr = 32'd0, seen_wdata = 32'd0;
   logic [3:0] seen_strobe = 4'd0;
   bus_op_t mop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Responder: stalls the first stall_n request cycles (or forever when hang), returns data the cycle after acceptance.
   initial forever begin
      @(posedge clk);
      #1;
      rdata = acc ? rd_value : 32'd0;
      error = acc && berr;
      acc = 0;
      if (wen || ren) begin
         req_len++;
         request_stall = hang || req_len <= stall_n;
         acc = !request_stall;
      end else begin
         req_len = 0;
         request_stall = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         chk("strobe", 32'(strobe), (wen || ren) ? 32'hf : 32'h0);
         chk("one_req", 32'(wen && ren), 32'h0);
         if ((wen || ren) && !prev_req) begin
            seen_addr = addr;
            seen_wdata = wdata;
            seen_strobe = strobe;
            mon_len = 0;
            if (exp_bus.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got wen=%0b ren=%0b expected none", wen, ren);
            end else begin
               mop = exp_bus[0];
               chk("req_kind", 32'(wen), 32'(mop.w));
               chk("req_addr", addr, mop.a);
               if (mop.w) chk("req_wdata", wdata, mop.d);
            end
         end
         if (wen || ren) mon_len++;
         if (!(wen || ren) && prev_req) begin
            last_len = mon_len;
            if (exp_bus.size() != 0) begin
               mop = exp_bus.pop_front();
               chk("req_len", 32'(mon_len), 32'(mop.len));
            end
         end
         prev_req = wen || ren;
         if (txValid && txReady) begin
            tx_log.push_back(txByte);
            if (exp_tx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx: got %h expected none", txByte);
            end else chk("tx_byte", 32'(txByte), 32'(exp_tx.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rxByte = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic start_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                              input int st, input bit hg, input logic [31:0] rv, input bit be);
      bus_op_t op;
      bit good, w;
      stall_n = st;
      hang = hg;
      rd_value = rv;
      berr = be;
      good = cmd == 8'h52 || cmd == 8'h57;
      w = cmd == 8'h57;
      if (good) begin
         op.w = w;
         op.a = a;
         op.d = d;
         op.len = hg ? 8 : st + 1;
         exp_bus.push_back(op);
      end
      if (!good || hg || be) exp_tx.push_back(8'h15);
      else begin
         exp_tx.push_back(8'h06);
         if (!w) for (int i = 0; i < 4; i++) exp_tx.push_back(rv[31-8*i -: 8]);
      end
      tx_log.delete();
      send_byte(cmd);
      if (good) for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
      if (good && w) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
      if (good) chk("req_rise", 32'(w ? wen : ren), 32'h1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (n < 300 && (busy || txValid || exp_tx.size() != 0 || exp_bus.size() != 0)) begin
         tick();
         n++;
      end
      chk("done_in_time", 32'(n < 300), 32'h1);
   endtask

   task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                            input int st, input bit hg, input logic [31:0] rv, input bit be);
      start_frame(cmd, a, d, st, hg, rv, be);
      wait_done();
   endtask

   task automatic chk_reset_vals();
      chk("rst_txByte", 32'(txByte), 32'h0);
      chk("rst_txValid", 32'(txValid), 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_strobe", 32'(strobe), 32'h0);
      chk("rst_wen", 32'(wen), 32'h0);
      chk("rst_ren", 32'(ren), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dropCount", 32'(dropCount), 32'h0);
   endtask

   initial begin
      logic [7:0] rd_exp [5];
      bit any_tx;
      int n;
      tick();
      tick();
      chk_reset_vals();
      reset = 1'b0;
      tick();

      run_frame(8'h57, 32'h0000000C, 32'hDEADBEEF, 0, 0, 32'h0, 0);
      chk("wr_addr", seen_addr, 32'h0000000C);
      chk("wr_wdata", seen_wdata, 32'hDEADBEEF);
      chk("wr_strobe", 32'(seen_strobe), 32'hf);
      chk("wr_len", 32'(last_len), 32'd1);
      chk("wr_resp_n", 32'(tx_log.size()), 32'd1);
      chk("wr_resp", 32'(tx_log[0]), 32'h06);

      run_frame(8'h52, 32'h00000004, 32'h0, 5, 0, 32'h11223344, 0);
      chk("rd_len", 32'(last_len), 32'd6);
      chk("rd_resp_n", 32'(tx_log.size()), 32'd5);
      rd_exp = '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 5 && i < tx_log.size(); i++) chk("rd_resp", 32'(tx_log[i]), 32'(rd_exp[i]));

      run_frame(8'hAA, 32'h0, 32'h0, 0, 0, 32'h0, 0);
      chk("bad_resp_n", 32'(tx_log.size()), 32'd1);
      chk("bad_resp", 32'(tx_log[0]), 32'h15);
      run_frame(8'h52, 32'h00000100, 32'h0, 0, 0, 32'hCAFEF00D, 0);
      chk("after_bad_addr", seen_addr, 32'h00000100);
      chk("after_bad_b1", 32'(tx_log[1]), 32'hCA);

      run_frame(8'h52, 32'h00000020, 32'h0, 0, 1, 32'h0, 0);
      chk("bto_len", 32'(last_len), 32'd8);
      chk("bto_resp", 32'(tx_log[0]), 32'h15);
      chk("bto_busy", 32'(busy), 32'h0);
      hang = 0;

      run_frame(8'h57, 32'h00000010, 32'h55AA55AA, 2, 0, 32'h0, 1);
      chk("err_resp", 32'(tx_log[0]), 32'h15);

      tx_log.delete();
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h00);
      chk("fto_busy_hi", 32'(busy), 32'h1);
      any_tx = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         any_tx |= txValid;
      end
      chk("fto_no_tx", 32'(any_tx), 32'h0);
      chk("fto_busy_lo", 32'(busy), 32'h0);
      run_frame(8'h57, 32'h00000044, 32'h01020304, 0, 0, 32'h0, 0);
      chk("fto_next_addr", seen_addr, 32'h00000044);
      chk("fto_next_resp", 32'(tx_log[0]), 32'h06);

      txReady = 1'b0;
      start_frame(8'h52, 32'h00000008, 32'h0, 0, 0, 32'hA1B2C3D4, 0);
      n = 0;
      while (n < 50 && !txValid) begin
         tick();
         n++;
      end
      chk("drop_hdr_valid", 32'(txValid), 32'h1);
      txReady = 1'b1;
      tick();
      txReady = 1'b0;
      tick();
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      tick();
      chk("drop_count", 32'(dropCount), 32'd3);
      chk("drop_data0", 32'(txByte), 32'hA1);
      txReady = 1'b1;
      wait_done();
      chk("drop_resp_n", 32'(tx_log.size()), 32'd5);

      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h0C);
      send_byte(8'hDE);
      chk("mid_addr", addr, 32'h0000000C);
      chk("mid_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      tick();
      chk_reset_vals();
      reset = 1'b0;
      tick();
      run_frame(8'h52, 32'h00000030, 32'h0, 1, 0, 32'h0BADF00D, 0);
      chk("post_rst_len", 32'(last_len), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Byte-stream-to-bus initiator: parses command frames arriving from a UART receiver byte stream, issues single 32-bit reads and writes as the initiator of the generic bus protocol, and returns response bytes to a UART transmitter. It sits opposite the AHB UART peripheral: that block is a bus responder fronting a UART; this block lets an external UART host drive the on-chip bus for debug and boot loading.

## Interface
- `FrameTimeout`, default 100000: idle clocks allowed between bytes of a partial frame before it is discarded.
- `BusTimeout`, default 1024: clocks `request_stall` may stay high before the access is abandoned.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `rxByte` in 8: received byte.
- `rxValid` in 1: one-cycle strobe, `rxByte` valid; no backpressure.
- `txByte` out 8: byte to transmit.
- `txValid` out 1: `txByte` valid; held until accepted.
- `txReady` in 1: transmitter accepts when `txValid && txReady`.
- `addr` out 32: bus address.
- `wdata` out 32: bus write data.
- `strobe` out 4: byte enables, always 4'b1111 during an access.
- `wen` out 1, `ren` out 1: bus write / read request.
- `rdata` in 32: read data.
- `request_stall` in 1: responder not ready.
- `error` in 1: responder error.
- `busy` out 1: high in every state except IDLE.
- `dropCount` out 8: saturating count of discarded `rxValid` bytes.

## Operation
- Frame: command byte, 4 address bytes MSB first, then for writes 4 data bytes MSB first. `0x52` ('R') = read, `0x57` ('W') = write.
- Responses: read OK = `0x06` then 4 data bytes MSB first; write OK = `0x06`; any failure = `0x15` alone.
- States: IDLE, ADDR, WDATA, BUS_REQ, BUS_DATA, RESP_HDR, RESP_DATA.
- IDLE: on `rxValid`, `0x52`/`0x57` latches the operation and enters ADDR with byte count 0. Any other byte enters RESP_HDR with `0x15`.
- ADDR: 4 bytes shift into the address register (`addr <= {addr[23:0], rxByte}`). After the 4th: read goes to BUS_REQ; write goes to WDATA.
- WDATA: 4 bytes shift into `wdata`, then BUS_REQ.
- BUS_REQ: drive `ren` or `wen` with `strobe`=4'b1111. The access is accepted in the first cycle with the request high and `request_stall`=0; that cycle's `error` is sampled. Then drop the request and go to BUS_DATA.
- BUS_DATA: one cycle. Capture `rdata` (registered by the responder); OR in `error` sampled this cycle. Go to RESP_HDR with `0x06`, or `0x15` on error.
- Bus timeout: stall counter reaches `BusTimeout` while in BUS_REQ -> drop request, RESP_HDR with `0x15`.
- RESP_HDR: present the header byte. On accept: successful read goes to RESP_DATA (4 bytes, MSB first); otherwise IDLE.
- Frame timeout: in ADDR/WDATA an idle counter resets on each `rxValid`. Reaching `FrameTimeout` returns to IDLE silently with no response.
- `rxValid` outside IDLE/ADDR/WDATA: byte discarded, `dropCount` increments, saturating at 255.
- Reset at any point: abort the frame or access immediately. There is no partial response.

## Timing
- Reset values: `txByte`=0, `txValid`=0, `addr`=0, `wdata`=0, `strobe`=0, `wen`=0, `ren`=0, `busy`=0, `dropCount`=0. State = IDLE, all counters 0.
- All outputs are registered.
- `wen`/`ren` rise the cycle after the last frame byte's `rxValid`. They are never both high.
- `wen`/`ren` fall the cycle after acceptance. With no stall the request is high exactly 1 cycle.
- `strobe` is 4'b1111 only while `wen` or `ren` is high, else 0.
- `txValid` rises the cycle after BUS_DATA, or the cycle after a timeout or bad-command decision.
- Consecutive response bytes: the next byte and `txValid` are presented the cycle after acceptance, so the gap is 1 cycle minimum.
- A new frame's command byte is accepted the cycle after the last response byte is accepted.
- `dropCount` updates the cycle after the dropped `rxValid`.

## Test plan
- Write: bytes 57 00 00 00 0C DE AD BE EF with no stall -> one-cycle `wen`, `addr`=0x0000000C, `wdata`=0xDEADBEEF, `strobe`=F; response `0x06`.
- Read with 5-cycle `request_stall`: 52 00 00 00 04, `rdata`=0x11223344 in the cycle after acceptance -> `ren` high 6 cycles; response 06 11 22 33 44, MSB first.
- Bad command 0xAA -> no bus activity; response `0x15`; the next valid frame is processed normally.
- Bus timeout: `BusTimeout`=8, stall held high -> request drops after 8 cycles; response `0x15`, `busy` returns low.
- Frame timeout: `FrameTimeout`=16, send 52 00 00 then idle 16 cycles -> back to IDLE, no tx. Then send 0x57 -> accepted as a command.
- Drop and reset: 3 bytes sent while in RESP_DATA with `txReady` low -> `dropCount`=3. Assert `reset` mid-write -> all outputs return to reset values the next cycle.
